// File: rtl/alu_seq_nbit_if.sv
// Request/response bundle between the register-file side and alu_seq_nbit.
// The master drives operands and start; the slave returns result, handshake and flags.
interface alu_seq_nbit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             div_zero;

  modport master (
    output start, alu_op, a, b,
    input  result, done, busy, carry_out, overflow, zero, div_zero
  );

  modport slave (
    input  start, alu_op, a, b,
    output result, done, busy, carry_out, overflow, zero, div_zero
  );
endinterface

// File: rtl/alu_seq_nbit.sv
// N-bit ALU with registered result/flags and a start/done handshake.
// Logic/arith ops finish at the accepting edge; mod runs WIDTH restoring-division steps.
module alu_seq_nbit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_nbit_if.slave bus
);

  typedef enum logic {IDLE, MOD_RUN} state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             cy_q, cy_d;
  logic             ov_q, ov_d;
  logic             zr_q, zr_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   add_sum, sub_sum;
  logic             add_ov, sub_ov;
  logic [WIDTH-1:0] op_res;
  logic             op_cy, op_ov;
  logic [WIDTH:0]   rem_trial, rem_diff;
  logic [WIDTH-1:0] rem_next;

  // Single-cycle datapath, evaluated straight from the request operands.
  always_comb begin
    add_sum = {1'b0, bus.a} + {1'b0, bus.b};
    sub_sum = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
    add_ov  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
    sub_ov  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_sum[WIDTH-1] != bus.a[WIDTH-1]);
    op_res  = '0;
    op_cy   = 1'b0;
    op_ov   = 1'b0;
    case (bus.alu_op)
      OP_AND: op_res = bus.a & bus.b;
      OP_OR:  op_res = bus.a | bus.b;
      OP_XOR: op_res = bus.a ^ bus.b;
      OP_NOR: op_res = ~(bus.a | bus.b);
      OP_SLT: begin
        op_res = {{(WIDTH-1){1'b0}}, sub_sum[WIDTH-1] ^ sub_ov};
        op_cy  = sub_sum[WIDTH];
        op_ov  = sub_ov;
      end
      OP_ADD: begin
        op_res = add_sum[WIDTH-1:0];
        op_cy  = add_sum[WIDTH];
        op_ov  = add_ov;
      end
      OP_SUB: begin
        op_res = sub_sum[WIDTH-1:0];
        op_cy  = sub_sum[WIDTH];
        op_ov  = sub_ov;
      end
      default: op_res = '0;
    endcase
  end

  // Restoring-division step; the partial remainder is kept one bit wider during
  // the compare so divisors with the MSB set still divide correctly.
  always_comb begin
    rem_trial = {rem_q, dvd_q[WIDTH-1]};
    rem_diff  = rem_trial - {1'b0, dvs_q};
    rem_next  = (rem_trial >= {1'b0, dvs_q}) ? rem_diff[WIDTH-1:0] : rem_trial[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    cy_d    = cy_q;
    ov_d    = ov_q;
    zr_d    = zr_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.alu_op != OP_MOD) begin
            res_d  = op_res;
            zr_d   = (op_res == '0);
            cy_d   = op_cy;
            ov_d   = op_ov;
            dz_d   = 1'b0;
            done_d = 1'b1;
          end else if (bus.b == '0) begin
            res_d  = bus.a;
            zr_d   = (bus.a == '0);
            cy_d   = 1'b0;
            ov_d   = 1'b0;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            rem_d   = '0;
            dvd_d   = bus.a;
            dvs_d   = bus.b;
            cnt_d   = '0;
            dz_d    = 1'b0;
            state_d = MOD_RUN;
          end
        end
      end
      MOD_RUN: begin
        rem_d = rem_next;
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          res_d   = rem_next;
          zr_d    = (rem_next == '0);
          cy_d    = 1'b0;
          ov_d    = 1'b0;
          dz_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      cy_q    <= 1'b0;
      ov_q    <= 1'b0;
      zr_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      cy_q    <= cy_d;
      ov_q    <= ov_d;
      zr_q    <= zr_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.result    = res_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q == MOD_RUN);
  assign bus.carry_out = cy_q;
  assign bus.overflow  = ov_q;
  assign bus.zero      = zr_q;
  assign bus.div_zero  = dz_q;

endmodule
